led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_seq_pkg.sv | 22 ++
 rtl/led_seq_prescaler.sv | 36 +++
 rtl/led_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode encodings and per-mode initial LED pattern for led_sequencer
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BINARY = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_e;

    localparam int MAX_LED = 16;

    // Callers truncate to their own LED width; all-ones stays all-ones.
    function automatic logic [MAX_LED-1:0] led_init_pattern(input led_mode_e mode);
        case (mode)
            MODE_BOUNCE, MODE_ROTATE: return 16'h0001;
            MODE_BINARY:              return 16'h0000;
            default:                  return 16'hFFFF;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// rtl/led_seq_prescaler.sv - free-running step prescaler with SPEED-selected tick and pause hold
module led_seq_prescaler #(
    parameter int DIV_W = 23
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] SPEED,
    input  logic       PAUSE,
    input  logic       clear,
    output logic       tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_mask;

    // Period 2^(DIV_W-SPEED), never shorter than 2 cycles.
    always_comb begin
        w_mask = {DIV_W{1'b1}};
        if ({4'b0000, SPEED} >= 6'(DIV_W - 1))
            w_mask = {DIV_W{1'b1}} >> (DIV_W - 1);
        else
            w_mask = {DIV_W{1'b1}} >> SPEED;
    end

    assign tick = !PAUSE && ((r_cnt & w_mask) == w_mask);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (!PAUSE)
            r_cnt <= r_cnt + DIV_W'(1);
    end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer (bounce/rotate/binary/blink); LED_SEQ_PWM_EN adds brightness PWM
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LED = 4,
    parameter int DIV_W = 23,
    parameter int PWM_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic [1:0]       SPEED,
    input  logic             PAUSE,
`ifdef LED_SEQ_PWM_EN
    input  logic [PWM_W-1:0] BRIGHT,
`endif
    output logic [N_LED-1:0] LED,
    output logic             TICK
);

    localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [POS_W-1:0] LAST = POS_W'(N_LED - 1);
    localparam bit PARAMS_OK = (N_LED >= 1) && (N_LED <= MAX_LED) &&
                               (DIV_W >= 2) && (DIV_W <= 32) && (PWM_W >= 1);

    generate
        if (!PARAMS_OK) begin : g_bad_params
        end
    endgenerate

    logic [1:0]       r_mode;
    logic             r_first;
    logic [POS_W-1:0] r_pos;
    logic             r_dir_up;
    logic [N_LED-1:0] r_ctr;
    logic [N_LED-1:0] r_pat;
    logic             r_tick;

    logic             w_tick;
    logic             w_restart;
    logic             w_step;
    logic [POS_W-1:0] w_pos_n;
    logic             w_dir_n;
    logic [N_LED-1:0] w_ctr_n;
    logic [N_LED-1:0] w_pat_n;
    logic [N_LED-1:0] w_pat_d;
    logic [N_LED-1:0] w_init;

    // The first active edge after reset is treated like a mode change.
    assign w_restart = !PAUSE && (r_first || (MODE != r_mode));
    assign w_step    = w_tick && !w_restart;
    assign w_init    = N_LED'(led_init_pattern(led_mode_e'(MODE)));

    led_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .CLK   (CLK),
        .RST   (RST),
        .SPEED (SPEED),
        .PAUSE (PAUSE),
        .clear (w_restart),
        .tick  (w_tick)
    );

    always_comb begin
        w_pos_n = r_pos;
        w_dir_n = r_dir_up;
        w_ctr_n = r_ctr;
        w_pat_n = r_pat;
        case (led_mode_e'(r_mode))
            MODE_BOUNCE: begin
                if (r_dir_up) begin
                    if (r_pos >= LAST) begin
                        w_dir_n = 1'b0;
                        w_pos_n = (N_LED == 1) ? '0 : r_pos - POS_W'(1);
                    end else begin
                        w_pos_n = r_pos + POS_W'(1);
                    end
                end else begin
                    if (r_pos == '0) begin
                        w_dir_n = 1'b1;
                        w_pos_n = (N_LED == 1) ? '0 : POS_W'(1);
                    end else begin
                        w_pos_n = r_pos - POS_W'(1);
                    end
                end
                w_pat_n = N_LED'(1) << w_pos_n;
            end
            MODE_ROTATE: begin
                w_pos_n = (r_pos >= LAST) ? '0 : r_pos + POS_W'(1);
                w_pat_n = N_LED'(1) << w_pos_n;
            end
            MODE_BINARY: begin
                w_ctr_n = r_ctr + N_LED'(1);
                w_pat_n = w_ctr_n;
            end
            default: begin
                w_pat_n = ~r_pat;
            end
        endcase
    end

    always_comb begin
        w_pat_d = r_pat;
        if (w_restart)
            w_pat_d = w_init;
        else if (w_step)
            w_pat_d = w_pat_n;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mode   <= 2'd0;
            r_first  <= 1'b1;
            r_pos    <= '0;
            r_dir_up <= 1'b1;
            r_ctr    <= '0;
            r_pat    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_step;
            r_pat  <= w_pat_d;
            if (!PAUSE) begin
                r_mode  <= MODE;
                r_first <= 1'b0;
            end
            if (w_restart) begin
                r_pos    <= '0;
                r_dir_up <= 1'b1;
                r_ctr    <= '0;
            end else if (w_step) begin
                r_pos    <= w_pos_n;
                r_dir_up <= w_dir_n;
                r_ctr    <= w_ctr_n;
            end
        end
    end

    assign TICK = r_tick;

`ifdef LED_SEQ_PWM_EN
    logic [PWM_W-1:0] r_pwm;
    logic [N_LED-1:0] r_led;

    // PWM keeps running while paused; only the underlying pattern is frozen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pwm <= '0;
            r_led <= '0;
        end else begin
            r_pwm <= r_pwm + PWM_W'(1);
            r_led <= w_pat_d & {N_LED{r_pwm < BRIGHT}};
        end
    end

    assign LED = r_led;
`else
    assign LED = r_pat;
`endif

endmodule
